// File: rtl/ff_fifo_ctrl.sv
// Synchronous show-ahead FIFO controller around a single ff_mem instance.
// Define FF_FIFO_HWM_EN to add the registered high-water-mark output hwm.
module ff_mem #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);
    logic [DW-1:0] mem [0:(2**AW)-1];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];
endmodule

module ff_fifo_ctrl #(
    parameter int DW        = 8,
    parameter int AW        = 4,
    parameter int AFULL_THR = 2**AW - 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic [AW:0]   count,
`ifdef FF_FIFO_HWM_EN
    output logic [AW:0]   hwm,
`endif
    output logic          almost_full
);
    localparam logic [AW:0] AFULL_LVL = (AW+1)'(AFULL_THR);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] count_next;
    logic        empty;
    logic        full;
    logic        push;
    logic        pop;
    logic        mem_wr_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    assign s_ready = !full;
    assign m_valid = !empty;

    assign push = s_valid && s_ready && !flush;
    assign pop  = m_valid && m_ready && !flush;

    // s_ready is already 1 while in reset, so the write must be blocked explicitly
    assign mem_wr_en = push && rst_n;

    always_comb begin
        count_next = count;
        if (flush)
            count_next = '0;
        else if (push && !pop)
            count_next = count + 1'b1;
        else if (pop && !push)
            count_next = count - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            almost_full <= 1'b0;
        end else begin
            count       <= count_next;
            almost_full <= (count_next >= AFULL_LVL);
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

`ifdef FF_FIFO_HWM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hwm <= '0;
        else if (flush)
            hwm <= '0;
        else if (count_next > hwm)
            hwm <= count_next;
    end
`endif

    ff_mem #(
        .DW(DW),
        .AW(AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (mem_wr_en),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (s_data),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (m_data)
    );
endmodule
